// File: rtl/oled_spi_rx.sv
// oled_spi_rx: snoops the PmodOLEDrgb SPI link (cs/sdin/sclk/d_cn) and rebuilds
// the RGB565 pixel stream the SSD1331 panel would receive, tracking the
// column (0x15) and row (0x75) address windows.
// Optional build macro OLED_RX_ERR_EN adds err_frame / err_count outputs that
// flag bytes cut short by a chip-select release.
module oled_spi_rx #(
    parameter int unsigned WIDTH       = 96,
    parameter int unsigned HEIGHT      = 64,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned XW = $clog2(WIDTH),
    localparam int unsigned YW = $clog2(HEIGHT),
    localparam int unsigned IW = $clog2(WIDTH * HEIGHT)
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          cs,
    input  logic          sdin,
    input  logic          sclk,
    input  logic          d_cn,
    output logic          pix_valid,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic [IW-1:0] pixel_index,
    output logic [15:0]   pix_data,
    output logic          frame_done,
`ifdef OLED_RX_ERR_EN
    output logic          err_frame,
    output logic [7:0]    err_count,
`endif
    output logic          cmd_valid,
    output logic [7:0]    cmd_byte
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COL_S,
        ST_COL_E,
        ST_ROW_S,
        ST_ROW_E
    } state_t;

    // Synchronizer chain, one 4-bit slice per stage: {cs, sdin, sclk, d_cn}
    logic [3:0] sync_q [SYNC_STAGES];
    logic       cs_s;
    logic       sdin_s;
    logic       sclk_s;
    logic       dcn_s;
    logic       sclk_prev_q;
    logic       sclk_rise;

    // Byte assembly
    logic [6:0] shift_q;
    logic [2:0] bit_cnt_q;
    logic       byte_valid_q;
    logic [7:0] byte_q;
    logic       byte_dc_q;

    // Parser and address tracking
    state_t     state_q;
    logic [XW-1:0] col_start_q;
    logic [XW-1:0] col_end_q;
    logic [YW-1:0] row_start_q;
    logic [YW-1:0] row_end_q;
    logic [XW-1:0] cur_x_q;
    logic [YW-1:0] cur_y_q;
    logic          phase_lo_q;
    logic [7:0]    hi_q;
    logic [XW-1:0] arg_x;
    logic [YW-1:0] arg_y;

    function automatic logic [XW-1:0] clip_x(input logic [7:0] v);
        return (32'(v) > WIDTH - 1) ? XW'(WIDTH - 1) : XW'(v);
    endfunction

    function automatic logic [YW-1:0] clip_y(input logic [7:0] v);
        return (32'(v) > HEIGHT - 1) ? YW'(HEIGHT - 1) : YW'(v);
    endfunction

    assign {cs_s, sdin_s, sclk_s, dcn_s} = sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign arg_x     = clip_x(byte_q);
    assign arg_y     = clip_y(byte_q);

    // Bring the asynchronous SPI nets into the CLK domain
    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= {cs, sdin, sclk, d_cn};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Shift in sdin on sclk rising edges; publish each complete byte for one cycle
    always_ff @(posedge CLK) begin
        if (reset) begin
            sclk_prev_q  <= 1'b0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            byte_valid_q <= 1'b0;
            byte_q       <= '0;
            byte_dc_q    <= 1'b0;
        end else begin
            sclk_prev_q  <= sclk_s;
            byte_valid_q <= 1'b0;
            if (cs_s) begin
                bit_cnt_q <= '0;
            end else if (sclk_rise) begin
                shift_q   <= {shift_q[5:0], sdin_s};
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    byte_valid_q <= 1'b1;
                    byte_q       <= {shift_q, sdin_s};
                    byte_dc_q    <= dcn_s;
                end
            end
        end
    end

`ifdef OLED_RX_ERR_EN
    // A chip-select release with bits pending marks a truncated byte
    always_ff @(posedge CLK) begin
        if (reset) begin
            err_frame <= 1'b0;
            err_count <= '0;
        end else if (cs_s && (bit_cnt_q != 3'd0)) begin
            err_frame <= 1'b1;
            if (err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end
`else
    // Truncated bytes are dropped without any record
`endif

    // Command parser, address windows and pixel assembly with registered strobes
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            col_start_q <= '0;
            col_end_q   <= XW'(WIDTH - 1);
            row_start_q <= '0;
            row_end_q   <= YW'(HEIGHT - 1);
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            phase_lo_q  <= 1'b0;
            hi_q        <= '0;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pixel_index <= '0;
            pix_data    <= '0;
            frame_done  <= 1'b0;
            cmd_valid   <= 1'b0;
            cmd_byte    <= '0;
        end else begin
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            cmd_valid  <= 1'b0;
            if (byte_valid_q) begin
                if (!byte_dc_q) begin
                    // Every command byte, arguments included, restarts the pixel phase
                    cmd_valid  <= 1'b1;
                    cmd_byte   <= byte_q;
                    phase_lo_q <= 1'b0;
                    case (state_q)
                        ST_IDLE: begin
                            if (byte_q == 8'h15) begin
                                state_q <= ST_COL_S;
                            end else if (byte_q == 8'h75) begin
                                state_q <= ST_ROW_S;
                            end
                        end
                        ST_COL_S: begin
                            col_start_q <= arg_x;
                            state_q     <= ST_COL_E;
                        end
                        ST_COL_E: begin
                            col_end_q <= (col_start_q > arg_x) ? col_start_q : arg_x;
                            cur_x_q   <= col_start_q;
                            state_q   <= ST_IDLE;
                        end
                        ST_ROW_S: begin
                            row_start_q <= arg_y;
                            state_q     <= ST_ROW_E;
                        end
                        ST_ROW_E: begin
                            row_end_q <= (row_start_q > arg_y) ? row_start_q : arg_y;
                            cur_y_q   <= row_start_q;
                            state_q   <= ST_IDLE;
                        end
                        default: state_q <= ST_IDLE;
                    endcase
                end else begin
                    // Data aborts any half-parsed window command
                    state_q <= ST_IDLE;
                    if (!phase_lo_q) begin
                        hi_q       <= byte_q;
                        phase_lo_q <= 1'b1;
                    end else begin
                        phase_lo_q  <= 1'b0;
                        pix_valid   <= 1'b1;
                        pix_x       <= cur_x_q;
                        pix_y       <= cur_y_q;
                        pixel_index <= IW'(cur_y_q) * IW'(WIDTH) + IW'(cur_x_q);
                        pix_data    <= {hi_q, byte_q};
                        if (cur_x_q == col_end_q) begin
                            cur_x_q <= col_start_q;
                            if (cur_y_q == row_end_q) begin
                                cur_y_q    <= row_start_q;
                                frame_done <= 1'b1;
                            end else begin
                                cur_y_q <= cur_y_q + YW'(1);
                            end
                        end else begin
                            cur_x_q <= cur_x_q + XW'(1);
                        end
                    end
                end
            end
        end
    end

endmodule
